pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register with valid/ready handshake, synchronous flush, and optional skid buffer. It generalises the fixed stall-and-hold stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) to any payload width. Back-pressure is carried by `out_ready` instead of a replayed copy of the last data. In skid mode the upstream `in_ready` is driven only from flops, which breaks the combinational stall path between stages. A per-stage saturating bubble counter is included for pipeline performance analysis.

## Interface
- `WIDTH`, default 64: payload width in bits; legal range ≥ 1.
- `SKID`, default 0: 0 selects a single register with combinational `in_ready`; 1 selects main plus skid register with registered `in_ready`.
- `CNT_W`, default 32: width of the bubble counter.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high
- `flush`  in  1  synchronous kill of all held entries (branch mispredict / exception)
- `in_valid`  in  1  upstream has payload
- `in_ready`  out  1  stage can accept payload this cycle
- `in_data`  in  WIDTH  upstream payload
- `out_valid`  out  1  stage holds a valid payload
- `out_ready`  in  1  downstream accepts; low means stall
- `out_data`  out  WIDTH  held payload
- `bubble_cnt`  out  CNT_W  count of cycles with `out_valid`=0, saturating

## Operation
- An input transfer occurs when `in_valid & in_ready` at a rising edge. An output transfer occurs when `out_valid & out_ready` at a rising edge.
- `out_data` changes only when a payload is loaded into the output register. It holds its value when idle, stalled or flushed; there is no zeroing.
- SKID=0:
  - `in_ready = out_ready | ~out_valid` (combinational).
  - On an edge with `in_ready`=1: `out_valid <= in_valid`. If `in_valid`=1, also `out_data <= in_data`.
  - With `in_ready`=0, all state holds (stall).
- SKID=1 uses a 3-state FSM:
  - EMPTY: main and skid empty. `out_valid`=0, `in_ready`=1.
    - Input transfer → ONE; main ← `in_data`.
  - ONE: main full. `out_valid`=1, `in_ready`=1.
    - Input and output transfer together → ONE; main ← `in_data`.
    - Input only → TWO; skid ← `in_data`.
    - Output only → EMPTY.
  - TWO: main and skid full. `out_valid`=1, `in_ready`=0.
    - Output transfer → ONE; main ← skid.
    - Otherwise hold.
  - `in_ready` is a flop, equal to (next state ≠ TWO). It has no combinational path from `out_ready`.
  - Ordering is strict FIFO: skid data always leaves after main data.
- Flush, both modes:
  - Next state is EMPTY and `out_valid` is 0.
  - An input transfer in the same cycle is discarded. Upstream is flushed by its own `flush`.
  - An output transfer in the same cycle counts as completed.
  - Flush has priority over every other event.
- `bubble_cnt`:
  - Increments by 1 on every edge where `out_valid`=0, including the flush cycle's successor.
  - Saturates at 2^CNT_W−1.
  - Not cleared by flush. Cleared only by `reset`.

## Timing
- Reset, asynchronous:
  - `out_valid`=0, `out_data`=0, `bubble_cnt`=0.
  - FSM=EMPTY, skid contents=0.
  - `in_ready`=1 in both modes; for SKID=0 this follows from `out_valid`=0.
- Reset deasserted mid-transfer: the first edge after deassertion behaves as EMPTY with no stale payload.
- Latency: `in_data` accepted at edge N appears on `out_data` after edge N. Skid-held data appears one edge after main drains.
- Throughput: 1 payload per cycle in both modes while `out_ready`=1.
- SKID=0 critical path: `out_ready` → `in_ready` is combinational. Chaining stages chains the path.
- SKID=1: `in_ready` falls one edge after the stall begins. The skid absorbs the in-flight payload, so no data is lost or duplicated.
- No payload is ever dropped or duplicated except by `flush`.

## Test plan
- Reset and idle, SKID=0/1: assert `reset` asynchronously mid-cycle, then run 10 idle cycles → outputs at reset values immediately; then `bubble_cnt`=10, `in_ready`=1.
- Streaming, SKID=1: send 0x1..0x8 back-to-back with `out_ready`=1 → `out_data` shows 0x1..0x8 on consecutive cycles, one cycle behind input, with `out_valid` high continuously.
- Stall absorb, SKID=1: send 0xA, 0xB, 0xC with `out_ready` low from cycle 1 → 0xA in main, 0xB in skid, `in_ready`=0, 0xC held upstream. Release `out_ready` → output sequence A, B, C with no loss.
- Stall, SKID=0: with `out_valid`=1 and `out_ready`=0 → `in_ready`=0 the same cycle, and `out_data` is stable over 5 cycles.
- Flush collision, SKID=1 in TWO: assert `flush` together with `in_valid` carrying 0xD → next cycle `out_valid`=0, FSM EMPTY, `in_ready`=1; 0xD never appears.
- Counter saturation, CNT_W=4: hold idle for 20 cycles → `bubble_cnt`=15 and it stays at 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready, flush, optional skid buffer
//
// Parameters:
//   WIDTH  payload width (>= 1)
//   SKID   0: single register, combinational in_ready
//          1: main + skid register, in_ready driven from a flop
//   CNT_W  width of the saturating bubble counter
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   flush       synchronous kill of all held entries
//   in_valid    upstream offers in_data
//   in_ready    stage accepts in_data this cycle
//   in_data     upstream payload
//   out_valid   stage holds a valid payload
//   out_ready   downstream accepts out_data
//   out_data    held payload (only changes when a payload is loaded)
//   bubble_cnt  saturating count of edges with out_valid low

module pipe_stage_reg #(
    parameter int WIDTH = 64,
    parameter int SKID  = 0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Bubble counter: counts idle output cycles, sticks at all-ones, survives flush.
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!out_valid && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = cnt_q;

    if (SKID == 0) begin : g_plain

        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        // Direct stall path: an empty stage or a draining stage can take new data.
        assign in_ready  = out_ready | ~valid_q;
        assign out_valid = valid_q;
        assign out_data  = data_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (in_ready) begin
                valid_q <= in_valid;
                if (in_valid) begin
                    data_q <= in_data;
                end
            end
        end

    end else begin : g_skid

        state_t           state_q;
        logic             valid_q;
        logic             ready_q;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;

        assign in_ready  = ready_q;
        assign out_valid = valid_q;
        assign out_data  = main_q;

        // valid_q and ready_q are kept as flops alongside the state so that
        // neither output has a combinational path from out_ready.
        // In EMPTY and ONE the stage is always ready, so in_valid alone
        // marks an input transfer there.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_EMPTY;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
                main_q  <= '0;
                skid_q  <= '0;
            end else if (flush) begin
                state_q <= ST_EMPTY;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_valid) begin
                            main_q  <= in_data;
                            state_q <= ST_ONE;
                            valid_q <= 1'b1;
                        end
                    end
                    ST_ONE: begin
                        case ({in_valid, out_ready})
                            2'b11: main_q <= in_data;
                            2'b10: begin
                                // Downstream stalled: park the in-flight payload.
                                skid_q  <= in_data;
                                state_q <= ST_TWO;
                                ready_q <= 1'b0;
                            end
                            2'b01: begin
                                state_q <= ST_EMPTY;
                                valid_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    ST_TWO: begin
                        if (out_ready) begin
                            main_q  <= skid_q;
                            state_q <= ST_ONE;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end

    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (plain, skid, small counter)

module tb_pipe_stage_reg;

    localparam int W  = 16;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // Channel 0: SKID=0 (dut0 and dut_sat share its inputs); channel 1: SKID=1.
    logic          flush0 = 1'b0, iv0 = 1'b0, or0 = 1'b0;
    logic [W-1:0]  id0 = '0;
    logic          ir0, ov0, irs, ovs;
    logic [W-1:0]  od0, ods;
    logic [CW-1:0] bc0;
    logic [3:0]    bcs;

    logic          flush1 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
    logic [W-1:0]  id1 = '0;
    logic          ir1, ov1;
    logic [W-1:0]  od1;
    logic [CW-1:0] bc1;

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(CW)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
        .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .bubble_cnt(bc0));

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush0), .in_valid(iv0), .in_ready(irs),
        .in_data(id0), .out_valid(ovs), .out_ready(or0), .out_data(ods), .bubble_cnt(bcs));

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .bubble_cnt(bc1));

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each stage is a FIFO of accepted payloads with capacity
    // 1 (plain) or 2 (skid); out_data is the FIFO head, or the last head shown.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] last0 = '0, last1 = '0;
    int           m_cnt0 = 0, m_cnt1 = 0, m_cnts = 0;

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    always @(posedge reset) begin
        q0.delete();
        q1.delete();
        last0  = '0;
        last1  = '0;
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_cnts = 0;
    end

    // Monitor: inputs are stable from posedge+1 to the next posedge, so the
    // negedge sees exactly what the coming edge will act on.
    always @(negedge clk) begin
        logic acc0, acc1, exp_ir0;
        if (!reset) begin
            exp_ir0 = or0 || (q0.size() == 0);
            chk("in_ready0", ir0, exp_ir0);
            chk("out_valid0", ov0, q0.size() != 0);
            if (q0.size() != 0) last0 = q0[0];
            chk("out_data0", od0, last0);
            chk("bubble0", bc0, m_cnt0);
            chk("in_ready_sat", irs, exp_ir0);
            chk("out_valid_sat", ovs, q0.size() != 0);
            chk("out_data_sat", ods, last0);
            chk("bubble_sat", bcs, m_cnts);

            chk("in_ready1", ir1, q1.size() < 2);
            chk("out_valid1", ov1, q1.size() != 0);
            if (q1.size() != 0) last1 = q1[0];
            chk("out_data1", od1, last1);
            chk("bubble1", bc1, m_cnt1);

            // Advance the model to the state after the coming edge.
            acc0 = iv0 && exp_ir0;
            acc1 = iv1 && (q1.size() < 2);
            if (q0.size() == 0) begin
                m_cnt0 = sat_inc(m_cnt0, 255);
                m_cnts = sat_inc(m_cnts, 15);
            end
            if (q1.size() == 0) m_cnt1 = sat_inc(m_cnt1, 255);

            if (flush0) q0.delete();
            else begin
                if (q0.size() != 0 && or0) void'(q0.pop_front());
                if (acc0) q0.push_back(id0);
            end
            if (flush1) q1.delete();
            else begin
                if (q1.size() != 0 && or1) void'(q1.pop_front());
                if (acc1) q1.push_back(id1);
            end
        end
    end

    // Hold a payload on channel 0 until it is taken (bounded).
    task automatic push0(input logic [W-1:0] v);
        int n;
        iv0 = 1'b1;
        id0 = v;
        n = 0;
        @(negedge clk);
        while (!ir0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir0) begin
            compared++;
            mismatched++;
            $display("FAIL push0_timeout: in_ready stayed 0 expected 1");
        end
        @(posedge clk);
        #1 iv0 = 1'b0;
    endtask

    task automatic push1(input logic [W-1:0] v);
        int n;
        iv1 = 1'b1;
        id1 = v;
        n = 0;
        @(negedge clk);
        while (!ir1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir1) begin
            compared++;
            mismatched++;
            $display("FAIL push1_timeout: in_ready stayed 0 expected 1");
        end
        @(posedge clk);
        #1 iv1 = 1'b0;
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    initial begin
        #400000;
        compared++;
        mismatched++;
        $display("FAIL watchdog: run did not complete in time");
        finish_run();
    end

    initial begin
        // Reset then idle: counters count the idle edges, small one saturates.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_bubble0", bc0, 10);
        chk("idle_bubble1", bc1, 10);
        chk("idle_in_ready0", ir0, 1);
        chk("idle_in_ready1", ir1, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("sat_bubble", bcs, 15);
        chk("bubble0_20", bc0, 20);

        // Streaming 1..8 back-to-back through the skid stage.
        or1 = 1'b1;
        for (int i = 1; i <= 8; i++) push1(W'(i));
        repeat (3) @(posedge clk);
        #1;

        // Stall absorb: A in main, B in skid, C waits upstream.
        or1 = 1'b0;
        push1(16'h000A);
        push1(16'h000B);
        fork
            push1(16'h000C);
            begin
                repeat (3) @(posedge clk);
                #1 or1 = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Plain stage stall: data held, in_ready low for 5 cycles.
        or0 = 1'b0;
        push0(16'h0055);
        repeat (5) @(posedge clk);
        #1 or0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Flush collision in TWO: 0xD must vanish.
        or1 = 1'b0;
        push1(16'h0011);
        push1(16'h0012);
        flush1 = 1'b1;
        iv1    = 1'b1;
        id1    = 16'h000D;
        @(posedge clk);
        #1;
        flush1 = 1'b0;
        iv1    = 1'b0;
        chk("flush_out_valid1", ov1, 0);
        chk("flush_in_ready1", ir1, 1);
        chk("flush_out_data1", od1, 16'h0011);
        or1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with payloads held.
        or0 = 1'b0;
        or1 = 1'b0;
        push0(16'h0077);
        push1(16'h0088);
        push1(16'h0099);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("areset_out_valid0", ov0, 0);
        chk("areset_out_data0", od0, 0);
        chk("areset_bubble0", bc0, 0);
        chk("areset_in_ready0", ir0, 1);
        chk("areset_out_valid1", ov1, 0);
        chk("areset_out_data1", od1, 0);
        chk("areset_bubble1", bc1, 0);
        chk("areset_in_ready1", ir1, 1);
        chk("areset_bubble_sat", bcs, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic with occasional flushes on both stages.
        for (int i = 0; i < 1500; i++) begin
            iv0    = 1'($urandom_range(0, 1));
            id0    = W'($urandom);
            or0    = ($urandom_range(0, 3) != 0);
            flush0 = ($urandom_range(0, 31) == 0);
            iv1    = 1'($urandom_range(0, 1));
            id1    = W'($urandom);
            or1    = ($urandom_range(0, 3) != 0);
            flush1 = ($urandom_range(0, 31) == 0);
            @(posedge clk);
            #1;
        end
        iv0    = 1'b0;
        iv1    = 1'b0;
        flush0 = 1'b0;
        flush1 = 1'b0;
        or0    = 1'b1;
        or1    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_out_valid0", ov0, 0);
        chk("drain_out_valid1", ov1, 0);
        finish_run();
    end

endmodule
